wallace_mul_arbiter: RTL and testbench
======================================

WALLACE_MUL_ARBITER -- requirements
Module: wallace_mul_arbiter

Interface
REQ-001 Parameter: CALC_CYCLES, default 2, cycles allowed for the shared 8x8 Wallace multiplier to settle; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req0_valid / req1_valid  input  1  requester N has an operand pair pending.
REQ-005 Port: req0_ready / req1_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 Port: req0_x, req0_y / req1_x, req1_y  input  8 each  unsigned operands of requester N.
REQ-007 Port: rsp0_valid / rsp1_valid  output  1  product for requester N available.
REQ-008 Port: rsp0_ready / rsp1_ready  input  1  requester N takes the product.
REQ-009 Port: rsp_z  output  16  registered product, shared by both responders.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: owner  output  1  index of requester whose operation is in flight (valid when busy).

Function
REQ-012 One internal instance of the 8x8 unsigned Wallace multiplier (full/half-adder tree, no pipeline registers), driven only from registered operands x_q, y_q.
REQ-013 FSM states: IDLE, CALC, RESP; no other states reachable.
REQ-014 IDLE: grant computed combinationally; only one valid -> that requester; both valid -> requester != last_served; none -> no grant.
REQ-015 IDLE: reqN_ready = 1 only for the granted requester; both ready low outside IDLE.
REQ-016 Handshake = reqN_valid & reqN_ready at a rising edge: x_q/y_q <= reqN operands, owner <= N, last_served <= N, cnt <= CALC_CYCLES-1, state -> CALC.
REQ-017 CALC: cnt decrements each cycle; at edge where cnt == 0, rsp_z <= multiplier output, state -> RESP.
REQ-018 Latency: handshake at edge E0 -> rsp_valid high after edge E(CALC_CYCLES).
REQ-019 RESP: rsp(owner)_valid = 1, other rsp_valid = 0; rsp_z held stable.
REQ-020 RESP: rsp(owner)_ready high at an edge -> state -> IDLE, rsp valid low next cycle; rsp_ready of the non-owner ignored.
REQ-021 Backpressure: RESP held indefinitely while rsp(owner)_ready low; no new request accepted.
REQ-022 Operand inputs and req_valid changes during CALC/RESP ignored; product always equals x_q*y_q latched at handshake.
REQ-023 Product exact, unsigned 16-bit, no truncation; 255*255 = 65025 (16'hFE01).
REQ-024 Peak throughput: one product per CALC_CYCLES+2 cycles (IDLE, CALC x CALC_CYCLES, RESP with rsp_ready already high).
REQ-025 Continuous requests from both sides: grants strictly alternate 0,1,0,1...; no starvation.
REQ-026 Requester dropping valid before handshake: no grant, no state change, last_served unchanged.

Reset
REQ-027 rst_n low: immediately state=IDLE, cnt=0, x_q=y_q=0, rsp_z=0, owner=0, last_served=1, all ready/valid outputs 0 except IDLE readiness per REQ-015 after release.
REQ-028 Reset asserted mid-CALC or mid-RESP: operation discarded, no response ever issued for it.
REQ-029 After rst_n release, first simultaneous request granted to requester 0.

Verification
REQ-030 CALC_CYCLES=2; req0 x=5 y=3 alone -> req0_ready in IDLE, rsp0_valid after 2nd edge past handshake, rsp_z=15, rsp1_valid stays 0.
REQ-031 Both valid same cycle, req0 7x2, req1 7x3 -> req0 served first rsp_z=14, then req1 rsp_z=21, owner 0 then 1.
REQ-032 req1 255x255 -> rsp_z=65025; req1 x=0 y=200 -> rsp_z=0.
REQ-033 rsp0_ready low 5 cycles in RESP, operands toggled meanwhile -> rsp0_valid and rsp_z stable 5 cycles, release on ready, busy falls next cycle.
REQ-034 Both requesters valid for 6 operations -> grant order 0,1,0,1,0,1; each rsp_z matches own latched operands.
REQ-035 rst_n pulsed low during CALC of 9x9 -> outputs reset asynchronously, no rsp valid for 81; next request 4x4 -> rsp_z=16.

Source files
------------

// File: rtl/wallace_mul_arbiter.sv
// Two-requester arbiter with round-robin tie-break that fronts one shared combinational 8x8 Wallace multiplier.
// The product appears CALC_CYCLES edges after the request handshake; the response is held until the owner's rsp_ready.

module wallace_mul8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    // One level of 3:2 compression: {sum, carry}, with the carry already weighted by one bit position.
    function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        logic [15:0] sum;
        logic [15:0] maj;
        sum = x ^ y ^ z;
        maj = (x & y) | (x & z) | (y & z);
        return {sum, maj[14:0], 1'b0};
    endfunction

    logic [15:0] pp [8];
    logic [15:0] s1a, c1a, s1b, c1b;
    logic [15:0] s2a, c2a, s2b, c2b;
    logic [15:0] s3, c3, s4, c4;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = b[i] ? ({8'd0, a} << i) : 16'd0;
        end
        // Eight partial-product rows are reduced 8 -> 6 -> 4 -> 3 -> 2 rows, then a single carry-propagate add.
        {s1a, c1a} = csa(pp[0], pp[1], pp[2]);
        {s1b, c1b} = csa(pp[3], pp[4], pp[5]);
        {s2a, c2a} = csa(s1a, c1a, s1b);
        {s2b, c2b} = csa(c1b, pp[6], pp[7]);
        {s3, c3}   = csa(s2a, c2a, s2b);
        {s4, c4}   = csa(s3, c3, c2b);
        p = s4 + c4;
    end
endmodule

module wallace_mul_arbiter #(
    parameter int unsigned CALC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_x,
    input  logic [7:0]  req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_x,
    input  logic [7:0]  req1_y,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp_z,
    output logic        busy,
    output logic        owner
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt;
    logic [7:0]  x_q;
    logic [7:0]  y_q;
    logic        last_served;
    logic [15:0] product;
    logic        grant_any;
    logic        grant_idx;
    logic        accept;
    logic        rsp_take;

    wallace_mul8 u_mul (
        .a (x_q),
        .b (y_q),
        .p (product)
    );

    // On contention the requester that was not served last wins.
    assign grant_any = req0_valid | req1_valid;
    assign grant_idx = (req0_valid & req1_valid) ? ~last_served : req1_valid;
    assign accept    = (state_q == IDLE) & grant_any;
    assign rsp_take  = (state_q == RESP) & (owner ? rsp1_ready : rsp0_ready);

    assign req0_ready = accept & ~grant_idx;
    assign req1_ready = accept & grant_idx;
    assign rsp0_valid = (state_q == RESP) & ~owner;
    assign rsp1_valid = (state_q == RESP) & owner;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (cnt == 4'd0) state_d = RESP;
            RESP:    if (rsp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 4'd0;
            x_q         <= 8'd0;
            y_q         <= 8'd0;
            rsp_z       <= 16'd0;
            owner       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            if (accept) begin
                x_q         <= grant_idx ? req1_x : req0_x;
                y_q         <= grant_idx ? req1_y : req0_y;
                owner       <= grant_idx;
                last_served <= grant_idx;
                cnt         <= 4'(CALC_CYCLES - 1);
            end
            if (state_q == CALC) begin
                if (cnt == 4'd0) begin
                    rsp_z <= product;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Directed stimulus against a cycle-level behavioural model, plus a log of delivered products checked against literals.
module tb_wallace_mul_arbiter;
    localparam int CALC_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]  req0_x, req0_y, req1_x, req1_y;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [15:0] rsp_z;
    logic        busy, owner;

    int errors = 0;
    int checks = 0;

    wallace_mul_arbiter #(.CALC_CYCLES(CALC_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_z      (rsp_z),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation is a product owed to one requester, delivered CALC_CYCLES edges after acceptance.
    bit m_busy  = 0;
    bit m_resp  = 0;
    int m_age   = 0;
    bit m_owner = 0;
    bit m_last  = 1;
    int m_z     = 0;
    int m_prod  = 0;

    function automatic bit m_pick();
        if (req0_valid && req1_valid) return !m_last;
        return req1_valid;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_resp = 0; m_age = 0; m_owner = 0; m_last = 1; m_z = 0; m_prod = 0;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_owner = m_pick();
                m_last  = m_owner;
                m_busy  = 1;
                m_age   = 0;
                m_prod  = m_owner ? int'(req1_x) * int'(req1_y) : int'(req0_x) * int'(req0_y);
            end
        end else if (!m_resp) begin
            m_age++;
            if (m_age == CALC_CYCLES) begin
                m_resp = 1;
                m_z    = m_prod;
            end
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_busy = 0;
            m_resp = 0;
        end
    end

    int log_own[$];
    int log_z[$];

    always @(negedge clk) begin
        bit any;
        bit g;
        any = !m_busy && (req0_valid || req1_valid);
        g   = m_pick();
        chk("req0_ready", int'(req0_ready), int'(any && !g));
        chk("req1_ready", int'(req1_ready), int'(any && g));
        chk("busy", int'(busy), int'(m_busy));
        chk("rsp0_valid", int'(rsp0_valid), int'(m_resp && !m_owner));
        chk("rsp1_valid", int'(rsp1_valid), int'(m_resp && m_owner));
        chk("rsp_z", int'(rsp_z), m_z);
        if (m_busy) chk("owner", int'(owner), int'(m_owner));
        if (rsp0_valid && rsp0_ready) begin log_own.push_back(0); log_z.push_back(int'(rsp_z)); end
        if (rsp1_valid && rsp1_ready) begin log_own.push_back(1); log_z.push_back(int'(rsp_z)); end
    end

    task automatic set_req(input int n, input bit v, input logic [7:0] x, input logic [7:0] y);
        if (n == 0) begin req0_valid = v; req0_x = x; req0_y = y; end
        else        begin req1_valid = v; req1_x = x; req1_y = y; end
    endtask

    // Returns one time unit after the accepting edge.
    task automatic issue(input int n, input logic [7:0] x, input logic [7:0] y, input bit drop);
        bit got = 0;
        set_req(n, 1'b1, x, y);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) begin got = 1; break; end
        end
        if (!got) chk("issue_timeout", 0, 1);
        @(posedge clk); #1;
        if (drop) set_req(n, 1'b0, x, y);
    endtask

    task automatic wait_rsp(input int n, input int exp_z);
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((n == 0) ? rsp0_valid : rsp1_valid) begin got = 1; break; end
        end
        if (!got) chk("rsp_timeout", 0, 1);
        else chk("rsp_z_literal", int'(rsp_z), exp_z);
    endtask

    task automatic stream(input int n);
        if (n == 0) begin
            issue(0, 8'd3, 8'd4, 1'b0);
            issue(0, 8'd10, 8'd20, 1'b0);
            issue(0, 8'd200, 8'd2, 1'b1);
        end else begin
            issue(1, 8'd6, 8'd7, 1'b0);
            issue(1, 8'd15, 8'd15, 1'b0);
            issue(1, 8'd128, 8'd255, 1'b1);
        end
    endtask

    int exp_own[13] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int exp_z[13]   = '{14, 21, 15, 65025, 0, 132, 16, 12, 42, 200, 225, 400, 32640};

    initial begin
        rst_n = 1'b0;
        set_req(0, 1'b0, 8'd0, 8'd0);
        set_req(1, 1'b0, 8'd0, 8'd0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rsp_z", int'(rsp_z), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous requests after reset: requester 0 first, then 1.
        fork
            issue(0, 8'd7, 8'd2, 1'b1);
            issue(1, 8'd7, 8'd3, 1'b1);
        join
        wait_rsp(1, 21);
        @(posedge clk); #1;

        // Lone request: response appears after the second edge past acceptance.
        issue(0, 8'd5, 8'd3, 1'b1);
        @(negedge clk); chk("lat_e0", int'(rsp0_valid), 0);
        @(negedge clk); chk("lat_e1", int'(rsp0_valid), 0);
        @(negedge clk); chk("lat_e2", int'(rsp0_valid), 1);
        chk("lat_z", int'(rsp_z), 15);
        chk("lat_rsp1", int'(rsp1_valid), 0);
        @(posedge clk); #1;

        issue(1, 8'd255, 8'd255, 1'b1);
        wait_rsp(1, 65025);
        @(posedge clk); #1;
        issue(1, 8'd0, 8'd200, 1'b1);
        wait_rsp(1, 0);
        @(posedge clk); #1;

        // Backpressure with operands and requests churning underneath.
        rsp0_ready = 1'b0;
        issue(0, 8'd12, 8'd11, 1'b1);
        wait_rsp(0, 132);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            set_req(0, 1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)));
            set_req(1, 1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)));
            @(negedge clk);
            chk("hold_valid", int'(rsp0_valid), 1);
            chk("hold_z", int'(rsp_z), 132);
            chk("hold_req1_ready", int'(req1_ready), 0);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 8'd0, 8'd0);
        set_req(1, 1'b0, 8'd0, 8'd0);
        rsp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("release_busy", int'(busy), 0);
        @(posedge clk); #1;

        // Reset in the middle of a calculation discards it.
        issue(0, 8'd9, 8'd9, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_rsp_z", int'(rsp_z), 0);
        chk("async_rsp0", int'(rsp0_valid), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_rsp_81", int'(rsp0_valid || rsp1_valid), 0);
        end
        @(posedge clk); #1;
        issue(1, 8'd4, 8'd4, 1'b1);
        wait_rsp(1, 16);
        @(posedge clk); #1;

        // Both requesters continuously valid: grants alternate.
        fork
            stream(0);
            stream(1);
        join
        wait_rsp(1, 32640);
        repeat (3) @(posedge clk);
        #1;

        chk("log_size", log_z.size(), 13);
        for (int i = 0; i < 13 && i < log_z.size(); i++) begin
            chk($sformatf("log_owner[%0d]", i), log_own[i], exp_own[i]);
            chk($sformatf("log_z[%0d]", i), log_z[i], exp_z[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
